// File: rtl/seq_checker_pkg.sv
// Shared definitions for the serial test-sequence generator/checker pair.
package seq_pkg;
  localparam logic [15:0] DEF_PATTERN = 16'b0111010011011010;
  localparam int PH_W   = 4;
  localparam int MISS_W = 4;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
endpackage

// File: rtl/seq_checker_if.sv
// Strobed serial input and checker status bundle.
interface seq_checker_if import seq_pkg::*; ();
  logic             bit_en;
  logic             din;
  logic             err_clr;
  logic             locked;
  logic             frame;
  logic             bit_err;
  logic [CNT_W-1:0] err_cnt;
  logic [5:0]       led_6bit;

  modport master (output bit_en, din, err_clr,
                  input  locked, frame, bit_err, err_cnt, led_6bit);
  modport slave  (input  bit_en, din, err_clr,
                  output locked, frame, bit_err, err_cnt, led_6bit);
endinterface

// File: rtl/seq_checker.sv
// Receive-side checker: aligns to a cyclic 16-bit sequence, verifies lock
// over one period, then counts bit errors while locked.
module seq_checker import seq_pkg::*; #(
  parameter logic [15:0] PATTERN     = DEF_PATTERN,
  parameter int          LOSS_THRESH = 4
) (
  input  logic          sysclk,
  input  logic          rst,
  seq_checker_if.slave  bus
);

  localparam logic [MISS_W-1:0] THRESH = MISS_W'(LOSS_THRESH);

  state_t            state;
  logic [15:0]       win;
  logic [PH_W-1:0]   ph;
  logic [MISS_W-1:0] miss;
  logic [CNT_W-1:0]  err_cnt;
  logic              locked;
  logic              frame;
  logic              bit_err;

  logic [15:0]       nxt;
  logic              hit;
  logic              count_err;
  logic [CNT_W-1:0]  cnt_base;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign nxt       = {win[14:0], bus.din};
  assign hit       = (bus.din == PATTERN[ph]);
  assign count_err = bus.bit_en && (state == LOCKED) && !hit;
  // Clear takes effect first so a coincident counted error leaves exactly one.
  assign cnt_base  = bus.err_clr ? '0 : err_cnt;

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state   <= SEARCH;
      win     <= '0;
      ph      <= '0;
      miss    <= '0;
      err_cnt <= '0;
      locked  <= 1'b0;
      frame   <= 1'b0;
      bit_err <= 1'b0;
    end else begin
      frame   <= 1'b0;
      bit_err <= 1'b0;
      err_cnt <= count_err ? sat_inc(cnt_base) : cnt_base;
      if (bus.bit_en) begin
        win <= nxt;
        // ph wraps 0 -> 15, which is exactly the reload needed at a period end.
        ph  <= ph - 1'b1;
        unique case (state)
          SEARCH: begin
            if (nxt == PATTERN) begin
              ph    <= '1;
              frame <= 1'b1;
              state <= VERIFY;
            end
          end
          VERIFY: begin
            if (!hit) begin
              state <= SEARCH;
            end else if (ph == '0) begin
              frame  <= 1'b1;
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
          LOCKED: begin
            if (!hit) begin
              bit_err <= 1'b1;
              if (miss + 1'b1 == THRESH) begin
                state  <= SEARCH;
                locked <= 1'b0;
                miss   <= '0;
              end else begin
                miss <= miss + 1'b1;
              end
            end else begin
              miss <= '0;
              if (ph == '0) frame <= 1'b1;
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.locked   = locked;
  assign bus.frame    = frame;
  assign bus.bit_err  = bit_err;
  assign bus.err_cnt  = err_cnt;
  assign bus.led_6bit = win[5:0];

endmodule

// File: doc/seq_checker.md
# seq_checker

Serial receive-side checker for the 16-bit test sequence 0111010011011010, transmitted MSB first and repeated cyclically. It samples one bit per `bit_en` strobe and aligns to the pattern. It then verifies lock over one full period and counts bit errors while locked. The last six received bits are mirrored onto the board LEDs, and the block sits at the far end of the sequence link on the same board clock.

## Interface
- `PATTERN`, default 16'b0111010011011010: expected cyclic sequence, MSB transmitted first.
- `LOSS_THRESH`, default 4: number of consecutive mismatches in LOCKED that forces a return to SEARCH; legal range 1–15.
- `sysclk`  in  1: board clock, all logic on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `bit_en`  in  1: one-`sysclk` strobe; `din` is valid and sampled only when high.
- `din`  in  1: serial data bit.
- `err_clr`  in  1: synchronous clear of `err_cnt`.
- `locked`  out  1: high in LOCKED state.
- `frame`  out  1: one-cycle pulse when an accepted bit completes a 16-bit window equal to `PATTERN`.
- `bit_err`  out  1: one-cycle pulse on each mismatching bit while LOCKED.
- `err_cnt`  out  16: saturating error count.
- `led_6bit`  out  6: last six received bits, newest in bit 0.

## Operation
- Shift register `win[15:0]`:
  - On `bit_en`, `win <= {win[14:0], din}`.
  - `nxt` is that new value.
  - `led_6bit = win[5:0]`.
- Phase counter `ph[3:0]` holds the index into `PATTERN` of the next expected bit. Expected bit is `PATTERN[ph]`. `ph` decrements on each accepted bit and wraps 0→15.
- **SEARCH:**
  - If `nxt == PATTERN`: set `ph` to 15, pulse `frame`, go to VERIFY.
  - Otherwise stay in SEARCH.
- **VERIFY:**
  - If `din != PATTERN[ph]`: go to SEARCH. No error is counted.
  - Else if `ph == 0`: the window completes the pattern again. Pulse `frame`, set `ph` to 15, go to LOCKED.
- **LOCKED:**
  - Mismatch: pulse `bit_err`, increment `err_cnt` (saturating at 16'hFFFF), increment the consecutive-miss counter `miss`.
    - If `miss + 1 == LOSS_THRESH`: go to SEARCH and clear `miss`.
  - Match: clear `miss`.
  - `frame` pulses when `ph == 0` and the bit matches.
  - `ph` advances on every accepted bit, matched or not, so alignment is held through isolated errors.
- `err_clr`:
  - Alone: `err_cnt` goes to 0.
  - Same cycle as a counted mismatch: result is 1 (clear, then count).
- Cycles without `bit_en` change nothing except `err_clr` handling. `frame` and `bit_err` are low in those cycles.

## Timing
- All outputs are registered and reflect a `bit_en` sample one `sysclk` later.
- `frame` and `bit_err` are high for exactly one `sysclk`.
- Reset values:
  - `locked`, `frame`, `bit_err`: 0.
  - `err_cnt`: 0.
  - `led_6bit`: 0.
  - `win`, `ph`, `miss`: 0.
  - State: SEARCH.
- Reset mid-operation aborts immediately with no residual pulses.
- Back-to-back `bit_en` (every cycle) is supported at full rate.
- Minimum time from the first aligned bit to `locked`:
  - 16 accepted bits fill the window (first `frame`).
  - 16 more accepted bits complete VERIFY.
  - `locked` rises the cycle after bit 32.
- `PATTERN` has no rotational self-match, so SEARCH cannot false-align on a correctly received stream.

## Structure
- Shared package `seq_pkg`:
  - Default `PATTERN` constant, shared with the generator.
  - State enum {SEARCH, VERIFY, LOCKED}.
  - Counter widths.
- Single module, no sub-modules. The strobe source (clock divider tick) lives outside.

## Test plan
- **Clean lock.** After reset, feed PATTERN ×4 with `bit_en` every cycle.
  - `frame` after bits 16, 32, 48 and 64.
  - `locked` high from bit 32 onward.
  - `err_cnt` = 0.
  - `led_6bit` = 6'b011010 after each period.
- **Offset start.** Feed 5 random bits, then PATTERN ×3.
  - First `frame` at bit 21.
  - `locked` after bit 37.
- **Single error while locked.** Invert one bit while LOCKED.
  - One `bit_err`, `err_cnt` = 1.
  - `locked` stays high.
  - Next `frame` is still on the period boundary.
- **Loss of lock.** With `LOSS_THRESH` = 4, invert 4 consecutive bits while LOCKED.
  - `err_cnt` = 4, `locked` drops after the 4th bit.
  - Relock 32 bits later on clean data.
- **VERIFY failure and clear.** Corrupt one bit during VERIFY.
  - Return to SEARCH, `err_cnt` unchanged.
  - Separately, `err_clr` coincident with a locked mismatch leaves `err_cnt` = 1.
- **Saturation and async reset.**
  - Force 70000 mismatches: `err_cnt` holds at 16'hFFFF.
  - Assert `rst` mid-stream: all outputs 0 asynchronously.
